// File: rtl/adbg_burst_crc_tx.sv
// Serial burst transmitter for the debug read path: shifts 32-bit words out LSB-first on tdo,
// then hands tdo to the external serial CRC-32 generator for the trailing 32 CRC bits.
module adbg_burst_crc_tx #(
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               shift_en,
  input  logic [31:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               tdo,
  output logic               crc_data,
  output logic               crc_en,
  output logic               crc_shift,
  output logic               crc_clr,
  input  logic               crc_serial,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  typedef enum logic [1:0] {IDLE, FIRST, DATA, CRC} state_t;

  state_t             state, state_nxt;
  logic [31:0]        sr;
  logic [31:0]        buf_data;
  logic               buf_v;
  logic [4:0]         bit_cnt;
  logic [BURST_W-1:0] word_cnt;
  logic               accept;
  logic               last_bit;

  // The holding buffer only opens during a burst, so nothing is accepted while idle.
  assign wr_ready = busy & ~buf_v;
  assign accept   = wr_valid & wr_ready;
  assign last_bit = shift_en && (bit_cnt == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (burst_len == '0) ? CRC : FIRST;
      FIRST: if (buf_v) state_nxt = DATA;
      DATA:  if (last_bit && (word_cnt == BURST_W'(1))) state_nxt = CRC;
      CRC:   if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tdo       = 1'b0;
    crc_data  = 1'b0;
    crc_en    = 1'b0;
    crc_shift = 1'b0;
    crc_clr   = 1'b0;
    case (state)
      IDLE: crc_clr = start;
      DATA: begin
        tdo      = sr[0];
        crc_data = sr[0];
        crc_en   = shift_en;
      end
      CRC: begin
        tdo       = crc_serial;
        crc_shift = shift_en;
      end
      default: ;
    endcase
  end

  // A word that misses its slot is replaced by zeros so the host-side bit count stays fixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      buf_data <= '0;
      buf_v    <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      if (accept) begin
        buf_data <= wr_data;
        buf_v    <= 1'b1;
      end
      case (state)
        IDLE: begin
          buf_v <= 1'b0;
          if (start) begin
            word_cnt <= burst_len;
            underrun <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        FIRST: begin
          if (shift_en) underrun <= 1'b1;
          if (buf_v) begin
            sr      <= buf_data;
            buf_v   <= 1'b0;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (shift_en) begin
            bit_cnt <= bit_cnt + 5'd1;
            sr      <= sr >> 1;
          end
          if (last_bit) begin
            word_cnt <= word_cnt - BURST_W'(1);
            if (word_cnt == BURST_W'(1)) begin
              bit_cnt <= '0;
            end else if (buf_v) begin
              sr    <= buf_data;
              buf_v <= 1'b0;
            end else begin
              sr       <= '0;
              underrun <= 1'b1;
            end
          end
        end
        CRC: begin
          if (shift_en) bit_cnt <= bit_cnt + 5'd1;
          if (last_bit) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adbg_burst_crc_tx.sv
// Scoreboard bench for adbg_burst_crc_tx with a behavioural serial CRC-32 generator attached
// and a word-list reference model for the expected tdo bitstream.
module tb_adbg_burst_crc_tx;

  localparam int BW = 16;
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          shift_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready, tdo, crc_data, crc_en, crc_shift, crc_clr, crc_serial;
  logic          busy, done, underrun;

  logic [31:0] crc_gen = '1;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt, sh_cnt, clr_cnt, done_cnt;
  bit exp_q[$];
  logic [31:0] words_q[$];

  adbg_burst_crc_tx #(.BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .shift_en(shift_en),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .tdo(tdo),
    .crc_data(crc_data), .crc_en(crc_en), .crc_shift(crc_shift), .crc_clr(crc_clr),
    .crc_serial(crc_serial), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Stand-in for the adjacent serial CRC generator the block drives.
  assign crc_serial = crc_gen[0];
  always @(posedge clk) begin
    if (crc_clr)        crc_gen <= '1;
    else if (crc_en)    crc_gen <= (crc_gen >> 1) ^ (((crc_gen[0] ^ crc_data) != 1'b0) ? POLY : 32'h0);
    else if (crc_shift) crc_gen <= crc_gen >> 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: the transmitted stream is the data bits LSB-first followed by the CRC-32
  // (reflected, init all ones, no final XOR) of exactly those bits, also LSB-first.
  task automatic pushExpected(input int len, input int withhold);
    bit          stream[$];
    logic [31:0] w;
    logic [31:0] crc;
    stream = {};
    for (int i = 0; i < len; i++) begin
      w = (i == withhold) ? 32'h0 : words_q[i];
      for (int b = 0; b < 32; b++) stream.push_back(w[b]);
    end
    crc = '1;
    foreach (stream[k]) crc = (crc >> 1) ^ (((crc[0] ^ stream[k]) != 1'b0) ? POLY : 32'h0);
    foreach (stream[k]) exp_q.push_back(stream[k]);
    for (int b = 0; b < 32; b++) exp_q.push_back(crc[b]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (crc_en)    en_cnt++;
      if (crc_shift) sh_cnt++;
      if (crc_clr)   clr_cnt++;
      if (done)      done_cnt++;
      if (busy) checkOutput("crc_en_shift_exclusive", {31'h0, crc_en & crc_shift}, 32'h0);
      if (done) checkOutput("busy_during_done", {31'h0, busy}, 32'h0);
      if (shift_en && busy) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL tdo_extra_bit: got %b, expected no more bits", tdo);
        end else begin
          checkOutput("tdo", {31'h0, tdo}, {31'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_tdo"}, {31'h0, tdo}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, "_wr_ready"}, {31'h0, wr_ready}, 32'h0);
    checkOutput({tag, "_crc_ctrl"}, {28'h0, crc_en, crc_shift, crc_clr, crc_data}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
    checkOutput({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
  endtask

  task automatic applyStimulus(input int len, input int duty, input bit gaps, input int withhold,
                               input bit spurious, input int reset_at);
    int idx = 0;
    bit acc;
    bit done_seen = 0;
    pushExpected(len, withhold);
    en_cnt = 0; sh_cnt = 0; clr_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = BW'(len);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        break;
      end
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (cyc == 2) checkOutput("underrun_cleared_by_start", {31'h0, underrun}, 32'h0);
      wr_valid = (idx < len) && (!gaps || $urandom_range(0, 3) != 0) && !(idx == withhold && cyc < 60);
      wr_data  = (idx < len) ? words_q[idx] : 32'h0;
      shift_en = (cyc >= 20) && ($urandom_range(0, 99) < duty);
      start    = spurious && (cyc == 40);
      burst_len = start ? BW'(7) : burst_len;
      if (cyc == reset_at) begin
        #2 rst_n = 1'b0;
        #1 checkIdleOutputs("async_reset");
        exp_q.delete();
        shift_en = 1'b0; wr_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    shift_en = 1'b0; wr_valid = 1'b0; start = 1'b0;
    if (!done_seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: no done pulse, expected one within 5000 cycles (len %0d)", len);
    end
    @(posedge clk); #1;
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("crc_clr_pulses", clr_cnt, 1);
    checkOutput("crc_en_cycles", en_cnt, 32 * len);
    checkOutput("crc_shift_cycles", sh_cnt, 32);
    checkOutput("bits_left", exp_q.size(), 0);
    checkOutput("busy_after_done", {31'h0, busy}, 32'h0);
    checkOutput("underrun_after_burst", {31'h0, underrun}, (withhold >= 0) ? 32'h1 : 32'h0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 checkIdleOutputs("reset");
    rst_n = 1'b1;

    words_q = {};
    applyStimulus(0, 100, 0, -1, 0, -1);

    words_q = {32'h0000_0000};
    applyStimulus(1, 100, 0, -1, 0, -1);

    words_q = {32'h0000_0001, 32'h8000_0000, 32'hA5A5_5A5A};
    applyStimulus(3, 100, 0, -1, 0, -1);

    words_q = {32'h1234_5678, 32'hCAFE_F00D};
    applyStimulus(2, 100, 0, 1, 0, -1);
    repeat (5) @(posedge clk);
    #1 checkOutput("underrun_sticky", {31'h0, underrun}, 32'h1);

    for (int t = 0; t < 4; t++) begin
      int len = $urandom_range(1, 4);
      words_q = {};
      for (int i = 0; i < len; i++) words_q.push_back($urandom);
      applyStimulus(len, 30, 1, -1, 0, -1);
    end

    words_q = {$urandom, $urandom};
    applyStimulus(2, 100, 0, -1, 0, 40);

    words_q = {32'hA5A5_5A5A, 32'h0F0F_F0F0, 32'h8000_0001};
    applyStimulus(3, 100, 0, -1, 1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adbg_burst_crc_tx.md
# adbg_burst_crc_tx

Serial burst transmitter for the debug interface read path. It accepts 32-bit words over a valid/ready handshake and shifts them out LSB-first on `tdo`, one bit per qualified `shift_en` cycle. It drives the adjacent serial CRC-32 generator with per-bit data and enable. After the last word it switches `tdo` to the generator's serial output for 32 more bits, so the host receives data followed by the CRC.

## Interface
- `BURST_W`, default 16: width of the word-count field.
- `clk` in 1: single clock; every register is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a burst; honoured only in IDLE.
- `burst_len` in BURST_W: number of data words; sampled when `start` is accepted.
- `shift_en` in 1: shift-DR qualifier; one output bit advances per cycle it is high.
- `wr_data` in 32: next data word.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: the block accepts a word when `wr_valid & wr_ready`.
- `tdo` out 1: serial output bit.
- `crc_data` out 1: data bit presented to the CRC generator.
- `crc_en` out 1: CRC generator advances with `crc_data`.
- `crc_shift` out 1: CRC generator shifts its register toward its serial output.
- `crc_clr` out 1: CRC generator is reinitialised to all ones.
- `crc_serial` in 1: CRC generator's serial output (its LSB).
- `busy` out 1: a burst is in progress.
- `done` out 1: one-cycle pulse after the final CRC bit.
- `underrun` out 1: sticky flag; cleared on the next accepted `start`.

## Operation
- States: IDLE, FIRST, DATA, CRC.
- Reset values:
  - State IDLE; shift register, buffer, bit counter and word counter 0.
  - `busy`, `done`, `underrun`, `wr_ready` and `tdo` all 0.
  - Combinational CRC controls 0.
- Storage:
  - One-entry holding buffer (`buf`, `buf_v`) plus a 32-bit shift register `sr`.
  - `wr_ready = busy & ~buf_v`; no combinational path from `shift_en`.
- IDLE:
  - `crc_clr = start` (combinational, IDLE only).
  - On `start`: latch `burst_len` into the word counter and clear `underrun`.
  - Then go to CRC if `burst_len == 0`, otherwise to FIRST.
- FIRST:
  - `tdo = 0`.
  - When `buf_v`: move `buf` into `sr`, clear `buf_v`, set bit counter to 0, go to DATA.
  - A `shift_en` seen in FIRST is dropped and sets `underrun`.
- DATA:
  - `tdo = crc_data = sr[0]`; `crc_en = shift_en`.
  - On `shift_en`: `sr >>= 1`, bit counter +1.
  - On `shift_en` with bit counter at 31: word counter −1.
    - Word counter reaches 0: go to CRC with bit counter 0.
    - Otherwise, `buf_v` set: load `buf` into `sr` and clear `buf_v`.
    - Otherwise: load `32'h0` into `sr` and set `underrun`; the burst continues and the zeros are included in the CRC.
- CRC:
  - `tdo = crc_serial`; `crc_shift = shift_en`.
  - After 32 `shift_en` cycles: pulse `done` next cycle, go to IDLE.
- Rules:
  - `crc_en` and `crc_shift` are never high together.
  - `start` outside IDLE is ignored.
  - Words written when no burst is active are not accepted (`wr_ready = 0`).
  - Surplus words left in `buf` at the end of a burst are discarded on return to IDLE.

## Timing
- `start` accepted in cycle N:
  - `crc_clr` is high in cycle N.
  - `busy` is high from N+1 until the cycle `done` pulses.
  - `done` is high for exactly one cycle; `busy` is 0 in that cycle.
- `tdo` is valid in the same cycle as the `shift_en` that consumes it; the next bit appears the cycle after.
- Buffer load and buffer refill in the same cycle: the consumed word leaves before the new one is written, and `wr_ready` recovers one cycle after consumption.
- `shift_en` may be held high continuously: burst of L words takes 32·L + 32 qualified cycles, with no gap at word or CRC boundaries.
- Word counter arithmetic is modulo 2^BURST_W, but it is never decremented below 0.
- `rst_n` low mid-burst returns all state to reset values immediately. `tdo` and the CRC controls go to 0 asynchronously.

## Test plan
- `burst_len=0`, `start`, then 32 `shift_en` cycles: `crc_clr` pulses once, `tdo` is 32 ones, `done` pulses once, `underrun=0`.
- `burst_len=1` with word `32'h0000_0000` and continuous `shift_en`: `tdo` is 32 zeros then `0xDEBB20E3` LSB-first, `crc_en` high for exactly 32 cycles, `crc_shift` high for exactly 32.
- `burst_len=3` with words `32'h1`, `32'h8000_0000`, `32'hA5A5_5A5A`, `wr_valid` held high: `tdo` matches the words LSB-first with no gaps, and the CRC bits match a reference CRC-32 model (reflected polynomial `0xEDB88320`, init all ones, no final XOR).
- `burst_len=2` with the second word withheld past the word boundary: 32 zero bits are sent, `underrun=1` sticks until the next `start`, and the CRC covers the zeros.
- Random `shift_en` duty (≈30%) with random `wr_valid` gaps: output bitstream identical to the continuous case, and `crc_en`/`crc_shift` never high together.
- `rst_n` low mid-DATA, then `start` asserted while `busy`: outputs reset immediately, and the `start` during `busy` has no effect.
